// File: rtl/pc_gen_btb.sv
// pc_gen_btb: fetch PC generator with a direct-mapped BTB of 2-bit counters
// and a latch that keeps a redirect which arrives while fetch cannot advance.
module pc_gen_btb #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                BTB_IDX_W    = 4,
    parameter int                STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               JumpFlag,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               upd_valid,
    input  logic [ADDR_W-1:0]  upd_pc,
    input  logic [ADDR_W-1:0]  upd_target,
    input  logic               upd_taken,
    output logic [ADDR_W-1:0]  pc,
    output logic               pc_valid,
    output logic               pred_taken,
    output logic [ADDR_W-1:0]  pred_target
);
    localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;
    localparam int N     = 1 << BTB_IDX_W;

    logic [ADDR_W-1:0]    pc_q, pc_d, pend_addr_q, pend_addr_d;
    logic                 pc_valid_q, pc_valid_d, pend_valid_q, pend_valid_d;
    logic [N-1:0]         vld_q, vld_d;
    logic [TAG_W-1:0]     tag_q [N];
    logic [TAG_W-1:0]     tag_d [N];
    logic [ADDR_W-1:0]    tgt_q [N];
    logic [ADDR_W-1:0]    tgt_d [N];
    logic [1:0]           ctr_q [N];
    logic [1:0]           ctr_d [N];
    logic [BTB_IDX_W-1:0] idx, uidx;
    logic [TAG_W-1:0]     utag;
    logic [ADDR_W-1:0]    jmp, utgt;
    logic [1:0]           uctr;
    logic                 hit, uhit, advance, unused_ok;

    assign jmp       = {jump_addr[ADDR_W-1:2], 2'b00};
    assign utgt      = {upd_target[ADDR_W-1:2], 2'b00};
    assign unused_ok = ^{stall[STALL_W-1:1], jump_addr[1:0], upd_target[1:0], upd_pc[1:0]};

    assign idx         = pc_q[BTB_IDX_W+1:2];
    assign hit         = vld_q[idx] && (tag_q[idx] == pc_q[ADDR_W-1:BTB_IDX_W+2]);
    assign pred_taken  = pc_valid_q & hit & ctr_q[idx][1];
    assign pred_target = pred_taken ? tgt_q[idx] : '0;
    assign pc          = pc_q;
    assign pc_valid    = pc_valid_q;

    assign advance = pc_valid_q & ~stall[0];

    always_comb begin
        pc_valid_d   = 1'b1;
        pc_d         = !advance     ? pc_q        :
                       JumpFlag     ? jmp         :
                       pend_valid_q ? pend_addr_q :
                       pred_taken   ? pred_target : pc_q + ADDR_W'(4);
        pend_valid_d = advance ? 1'b0 : (pend_valid_q | JumpFlag);
        pend_addr_d  = (!advance && JumpFlag) ? jmp : pend_addr_q;
    end

    assign uidx = upd_pc[BTB_IDX_W+1:2];
    assign utag = upd_pc[ADDR_W-1:BTB_IDX_W+2];
    assign uhit = vld_q[uidx] && (tag_q[uidx] == utag);
    assign uctr = ctr_q[uidx];

    // Training writes land next edge, so a same-cycle lookup sees old contents.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        tgt_d = tgt_q;
        ctr_d = ctr_q;
        if (upd_valid) begin
            vld_d[uidx] = 1'b1;
            tag_d[uidx] = utag;
            tgt_d[uidx] = (!uhit || upd_taken) ? utgt : tgt_q[uidx];
            ctr_d[uidx] = !uhit     ? (upd_taken ? 2'b10 : 2'b01) :
                          upd_taken ? ((uctr == 2'b11) ? uctr : uctr + 2'd1) :
                                      ((uctr == 2'b00) ? uctr : uctr - 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            vld_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            vld_q        <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        ctr_q <= ctr_d;
    end
endmodule

// File: tb/tb_pc_gen_btb.sv
// tb_pc_gen_btb: directed stimulus for pc_gen_btb; expected outputs are queued
// per cycle and a negedge monitor pops and compares them.
module tb_pc_gen_btb;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        jf;
    logic [31:0] ja;
    logic        uv;
    logic [31:0] upc, ut;
    logic        tk;
    logic [31:0] pc, pred_target;
    logic        pc_valid, pred_taken;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    pc_gen_btb dut (
        .clk(clk), .rst(rst), .stall(stall), .JumpFlag(jf), .jump_addr(ja),
        .upd_valid(uv), .upd_pc(upc), .upd_target(ut), .upd_taken(tk),
        .pc(pc), .pc_valid(pc_valid), .pred_taken(pred_taken), .pred_target(pred_target)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({pc_valid, pc, pred_taken, pred_target} !== {e.v, e.pc, e.pt, e.tgt}) begin
                failures++;
                $display("FAIL %s: got v=%0b pc=%h pt=%0b tgt=%h, expected v=%0b pc=%h pt=%0b tgt=%h",
                         e.name, pc_valid, pc, pred_taken, pred_target, e.v, e.pc, e.pt, e.tgt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string n, input logic v, input logic [31:0] p,
                       input logic t = 1'b0, input logic [31:0] g = 32'h0);
        exp_t x;
        x.name = n; x.v = v; x.pc = p; x.pt = t; x.tgt = g;
        q.push_back(x);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; stall = '0; jf = 1'b0; ja = '0;
        uv = 1'b0; upc = '0; ut = '0; tk = 1'b0;
        tick();
        rst = 1'b1;
        cyc("reset", 0, 32'h0);
        cyc("start", 1, 32'h0);
        cyc("adv4", 1, 32'h4);
        cyc("adv8", 1, 32'h8);
        jf = 1; ja = 32'h103;
        cyc("advC", 1, 32'hC);
        jf = 0;
        cyc("jmp100", 1, 32'h100);
        stall = 6'h1; jf = 1; ja = 32'h200;
        cyc("jmp104", 1, 32'h104);
        ja = 32'h300;
        cyc("stall1", 1, 32'h104);
        jf = 0;
        cyc("stall2", 1, 32'h104);
        stall = '0;
        cyc("stall3", 1, 32'h104);
        cyc("pend300", 1, 32'h300);
        uv = 1; upc = 32'h10; ut = 32'h80; tk = 1; jf = 1; ja = 32'h8;
        cyc("p304", 1, 32'h304);
        jf = 0;
        cyc("p8", 1, 32'h8);
        uv = 0;
        cyc("pC", 1, 32'hC);
        cyc("pred10", 1, 32'h10, 1, 32'h80);
        uv = 1; tk = 0; ut = 32'h999;
        cyc("tgt80", 1, 32'h80);
        uv = 0; jf = 1; ja = 32'h10;
        cyc("p84", 1, 32'h84);
        jf = 0; uv = 1;
        cyc("weak10", 1, 32'h10, 1, 32'h80);
        uv = 0; jf = 1; ja = 32'h10;
        cyc("samecyc80", 1, 32'h80);
        jf = 0;
        cyc("nt10", 1, 32'h10);
        uv = 1; upc = 32'h10; ut = 32'h80; tk = 1; jf = 1; ja = 32'h10;
        cyc("p14", 1, 32'h14);
        jf = 0; upc = 32'h50; ut = 32'h40;
        cyc("hit10", 1, 32'h10, 1, 32'h80);
        uv = 0; jf = 1; ja = 32'h10;
        cyc("pr80", 1, 32'h80);
        ja = 32'h50;
        cyc("alias10", 1, 32'h10);
        jf = 0;
        cyc("hit50", 1, 32'h50, 1, 32'h40);
        jf = 1; ja = 32'hFFFF_FFFC;
        cyc("p40", 1, 32'h40);
        jf = 0;
        cyc("top", 1, 32'hFFFF_FFFC);
        stall = 6'h1; jf = 1; ja = 32'h500;
        cyc("wrap0", 1, 32'h0);
        jf = 0;
        cyc("held0", 1, 32'h0);
        rst = 0; stall = '0;
        cyc("midrst", 0, 32'h0);
        rst = 1;
        cyc("rstheld", 0, 32'h0);
        cyc("restart", 1, 32'h0);
        cyc("nopend", 1, 32'h4);
        jf = 1; ja = 32'h10;
        cyc("p8b", 1, 32'h8);
        ja = 32'h50;
        cyc("miss10", 1, 32'h10);
        jf = 0;
        cyc("miss50", 1, 32'h50);
        repeat (2) tick();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
